// File: rtl/nnoc_pkg.sv
// Shared constants and types for the NN accelerator datapath.
// Sizes the PE array, the skew buffer and its feed controller.
package nnoc_pkg;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int DATA_W     = 8;
    localparam int TILE_CNT_W = 8;
    localparam int PE_LAT     = 2;

    typedef logic [DATA_W-1:0] act_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TILE,
        DRAIN,
        FLUSH
    } skew_state_e;

endpackage

// File: rtl/skew_feed_ctrl.sv
// Sequencer for the 4x4 activation skew buffer feeding the PE array.
// Loads tiles, tracks the diagonal drain, flags first tile and job end.
module skew_feed_ctrl
    import nnoc_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [TILE_CNT_W-1:0]        num_tiles,
    input  logic                         tile_valid,
    input  logic [ROWS*COLS*DATA_W-1:0]  tile_data,
    output logic                         tile_ready,
    output logic                         sb_load,
    output logic [ROWS*COLS*DATA_W-1:0]  sb_activation,
    output logic [ROWS-1:0]              row_valid,
    output logic                         acc_clear,
    output logic                         busy,
    output logic                         done
);

    localparam int D_W = $clog2(ROWS + COLS - 1);
    localparam int F_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [D_W-1:0] D_LAST = D_W'(ROWS + COLS - 2);
    localparam logic [F_W-1:0] F_LAST = F_W'(PE_LAT - 1);

    skew_state_e           state_q, state_d;
    logic [TILE_CNT_W-1:0] rem_q, rem_d;
    logic                  first_q, first_d;
    logic [D_W-1:0]        d_q, d_d;
    logic [F_W-1:0]        f_q, f_d;
    logic                  done_q, done_d;
    logic [TILE_CNT_W-1:0] rem_dec;
    int                    dv;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            first_q <= 1'b0;
            d_q     <= '0;
            f_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            first_q <= first_d;
            d_q     <= d_d;
            f_q     <= f_d;
            done_q  <= done_d;
        end
    end

    assign rem_dec = (rem_q != '0) ? rem_q - TILE_CNT_W'(1) : rem_q;
    assign dv      = int'(d_q);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        first_d    = first_q;
        d_d        = d_q;
        f_d        = f_q;
        done_d     = 1'b0;
        tile_ready = 1'b0;
        row_valid  = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_tiles == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = num_tiles;
                        first_d = 1'b1;
                        state_d = WAIT_TILE;
                    end
                end
            end
            WAIT_TILE: begin
                tile_ready = 1'b1;
                if (tile_valid) begin
                    first_d = 1'b0;
                    rem_d   = rem_dec;
                    d_d     = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                for (int r = 0; r < ROWS; r++) begin
                    row_valid[r] = (r <= dv) && (dv <= r + COLS - 1);
                end
                if (d_q == D_LAST) begin
                    if (rem_q != '0) begin
                        // Back-to-back reload: old tail rows still drive this cycle.
                        tile_ready = 1'b1;
                        if (tile_valid) begin
                            first_d = 1'b0;
                            rem_d   = rem_dec;
                            d_d     = '0;
                        end else begin
                            state_d = WAIT_TILE;
                        end
                    end else begin
                        f_d     = '0;
                        state_d = FLUSH;
                    end
                end else begin
                    d_d = d_q + D_W'(1);
                end
            end
            FLUSH: begin
                if (f_q == F_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    f_d = f_q + F_W'(1);
                end
            end
        endcase
    end

    assign sb_load       = tile_valid & tile_ready;
    assign acc_clear     = sb_load & first_q;
    assign sb_activation = tile_data;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_skew_feed_ctrl.sv
// Directed bench for skew_feed_ctrl: cycle tables plus corner sequences.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_skew_feed_ctrl;
    import nnoc_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   num_tiles;
    logic         tile_valid;
    logic [127:0] tile_data;
    logic         tile_ready;
    logic         sb_load;
    logic [127:0] sb_activation;
    logic [3:0]   row_valid;
    logic         acc_clear;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    skew_feed_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_tiles     (num_tiles),
        .tile_valid    (tile_valid),
        .tile_data     (tile_data),
        .tile_ready    (tile_ready),
        .sb_load       (sb_load),
        .sb_activation (sb_activation),
        .row_valid     (row_valid),
        .acc_clear     (acc_clear),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        logic       st;
        logic [7:0] n;
        logic       tv;
        logic       tr;
        logic       sb;
        logic       ac;
        logic [3:0] rv;
        logic       bz;
        logic       dn;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] rvp[7];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [7:0] n, input logic tv,
                       input logic tr, input logic sb, input logic ac,
                       input logic [3:0] rv, input logic bz, input logic dn);
        vec_t v;
        v.st = st; v.n = n; v.tv = tv;
        v.tr = tr; v.sb = sb; v.ac = ac;
        v.rv = rv; v.bz = bz; v.dn = dn;
        tbl.push_back(v);
    endtask

    // Seven drain cycles; the last may offer a reload.
    task automatic add_drain(input logic st, input logic [7:0] n,
                             input logic tv, input logic reload);
        for (int k = 0; k < 7; k++) begin
            if (k == 6)
                add(st, n, tv, reload, reload & tv, 1'b0, rvp[k], 1'b1, 1'b0);
            else
                add(st, n, tv, 1'b0, 1'b0, 1'b0, rvp[k], 1'b1, 1'b0);
        end
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            @(negedge clk);
            start      = tbl[i].st;
            num_tiles  = tbl[i].n;
            tile_valid = tbl[i].tv;
            #1;
            chk($sformatf("%s[%0d].tile_ready", tag, i), tile_ready, tbl[i].tr);
            chk($sformatf("%s[%0d].sb_load", tag, i), sb_load, tbl[i].sb);
            chk($sformatf("%s[%0d].acc_clear", tag, i), acc_clear, tbl[i].ac);
            chk($sformatf("%s[%0d].row_valid", tag, i), row_valid, tbl[i].rv);
            chk($sformatf("%s[%0d].busy", tag, i), busy, tbl[i].bz);
            chk($sformatf("%s[%0d].done", tag, i), done, tbl[i].dn);
        end
        tbl.delete();
    endtask

    task automatic drive(input logic st, input logic [7:0] n, input logic tv);
        @(negedge clk);
        start      = st;
        num_tiles  = n;
        tile_valid = tv;
        #1;
    endtask

    initial begin
        int dones;
        int lat;
        logic got;

        rvp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        for (int b = 0; b < 16; b++) tile_data[b*8 +: 8] = 8'(b + 1);

        reset = 1'b1; start = 1'b0; num_tiles = '0; tile_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.tile_ready", tile_ready, 1'b0);
        chk("rst.sb_load", sb_load, 1'b0);
        chk("rst.row_valid", row_valid, 4'b0);
        chk("rst.acc_clear", acc_clear, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("passthru", sb_activation, 128'h100F0E0D0C0B0A090807060504030201);
        @(negedge clk);
        reset = 1'b0;

        // Single tile, tile_valid held high.
        add(1, 8'd1, 1, 0, 0, 0, 4'b0, 0, 0);
        add(0, 8'd0, 1, 1, 1, 1, 4'b0, 1, 0);
        add_drain(0, 8'd0, 1, 0);
        add(0, 8'd0, 1, 0, 0, 0, 4'b0, 1, 0);
        add(0, 8'd0, 1, 0, 0, 0, 4'b0, 1, 0);
        add(0, 8'd0, 1, 0, 0, 0, 4'b0, 0, 1);
        add(0, 8'd0, 1, 0, 0, 0, 4'b0, 0, 0);
        run_table("one");

        // Three tiles back to back, no gap between drains.
        add(1, 8'd3, 1, 0, 0, 0, 4'b0, 0, 0);
        add(0, 8'd0, 1, 1, 1, 1, 4'b0, 1, 0);
        add_drain(0, 8'd0, 1, 1);
        add_drain(0, 8'd0, 1, 1);
        add_drain(0, 8'd0, 1, 0);
        add(0, 8'd0, 1, 0, 0, 0, 4'b0, 1, 0);
        add(0, 8'd0, 1, 0, 0, 0, 4'b0, 1, 0);
        add(0, 8'd0, 1, 0, 0, 0, 4'b0, 0, 1);
        add(0, 8'd0, 0, 0, 0, 0, 4'b0, 0, 0);
        run_table("three");

        // Zero-tile job, then start held high through a busy job.
        add(1, 8'd0, 0, 0, 0, 0, 4'b0, 0, 0);
        add(0, 8'd0, 0, 0, 0, 0, 4'b0, 0, 1);
        add(0, 8'd0, 0, 0, 0, 0, 4'b0, 0, 0);
        add(1, 8'd2, 0, 0, 0, 0, 4'b0, 0, 0);
        add(1, 8'd7, 0, 1, 0, 0, 4'b0, 1, 0);
        add(1, 8'd7, 1, 1, 1, 1, 4'b0, 1, 0);
        add_drain(1, 8'd5, 1, 1);
        add_drain(1, 8'd5, 1, 0);
        add(1, 8'd9, 1, 0, 0, 0, 4'b0, 1, 0);
        add(1, 8'd9, 1, 0, 0, 0, 4'b0, 1, 0);
        add(0, 8'd0, 0, 0, 0, 0, 4'b0, 0, 1);
        add(0, 8'd0, 0, 0, 0, 0, 4'b0, 0, 0);
        run_table("zero_busy");

        // Two tiles with tile_valid dropped for 5 cycles after the first drain.
        drive(1, 8'd2, 1);
        drive(0, 8'd0, 1);
        chk("stall.first_load", sb_load, 1'b1);
        chk("stall.first_clear", acc_clear, 1'b1);
        for (int k = 0; k < 6; k++) drive(0, 8'd0, 1);
        chk("stall.d5_rv", row_valid, 4'b1100);
        drive(0, 8'd0, 0);
        chk("stall.d6_ready", tile_ready, 1'b1);
        chk("stall.d6_load", sb_load, 1'b0);
        chk("stall.d6_rv", row_valid, 4'b1000);
        for (int k = 0; k < 4; k++) begin
            drive(0, 8'd0, 0);
            chk($sformatf("stall.w%0d_ready", k), tile_ready, 1'b1);
            chk($sformatf("stall.w%0d_load", k), sb_load, 1'b0);
            chk($sformatf("stall.w%0d_rv", k), row_valid, 4'b0);
            chk($sformatf("stall.w%0d_busy", k), busy, 1'b1);
        end
        drive(0, 8'd0, 1);
        chk("stall.reload", sb_load, 1'b1);
        chk("stall.reload_clear", acc_clear, 1'b0);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            drive(0, 8'd0, 0);
            if (k == 1) chk("stall.rv_after", row_valid, 4'b0001);
            if (done) begin
                got = 1'b1;
                lat = k;
            end
        end
        chk("stall.done_seen", got, 1'b1);
        chk("stall.done_lat", 32'(lat), 32'd10);

        // Reset in the middle of a drain.
        for (int b = 0; b < 16; b++) tile_data[b*8 +: 8] = 8'(8'hA0 + b);
        chk("passthru2", sb_activation, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
        drive(1, 8'd1, 1);
        drive(0, 8'd0, 1);
        for (int k = 0; k < 4; k++) drive(0, 8'd0, 1);
        chk("rstmid.d3_rv", row_valid, 4'b1111);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid.busy", busy, 1'b0);
        chk("rstmid.rv", row_valid, 4'b0);
        chk("rstmid.ready", tile_ready, 1'b0);
        chk("rstmid.load", sb_load, 1'b0);
        chk("rstmid.clear", acc_clear, 1'b0);
        chk("rstmid.done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            drive(0, 8'd0, 1);
            if (done) dones++;
        end
        chk("rstmid.no_done", 32'(dones), 32'd0);
        chk("rstmid.idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
